vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port frame-memory arbiter: display reads pre-empt buffered pixel writes.
// Reads: address same cycle, data one cycle later. Writes: commit one cycle after accept at the earliest.
// Backpressure: wr_ready falls only while the 2-entry write buffer is full; display is never stalled.
module vram_arbiter #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12,
   parameter int DEPTH  = 76800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_valid,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_done,
   input  logic              err_clr,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   // One extra bit so DEPTH itself (2^ADDR_W boundary cases included) fits the compare.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t              state;
   occ_t              state_nxt;

   // Head slot is always the oldest entry; tail slot is only valid in FULL.
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [ADDR_W-1:0] tail_addr;
   logic [DATA_W-1:0] tail_data;

   logic              accept;
   logic              drain;
   logic              head_in_range;
   logic              load_head_wr;
   logic              load_head_tail;
   logic              load_tail_wr;
   logic              rd_issued;

   // Ready comes straight from the occupancy register so it never loops through the writer.
   assign wr_ready      = (state != FULL);
   assign accept        = wr_valid && wr_ready;
   assign drain         = !disp_valid && (state != EMPTY);
   assign head_in_range = ({1'b0, head_addr} < DEPTH_X);

   // Occupancy register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next occupancy and which slot loads what; an accept in EMPTY only fills the buffer,
   // it never reaches memory the same cycle.
   always_comb begin
      state_nxt      = state;
      load_head_wr   = 1'b0;
      load_head_tail = 1'b0;
      load_tail_wr   = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt    = ONE;
               load_head_wr = 1'b1;
            end
         end
         ONE: begin
            if (accept && drain) begin
               // Old head leaves, new entry becomes the head: order preserved.
               load_head_wr = 1'b1;
            end else if (accept) begin
               state_nxt    = FULL;
               load_tail_wr = 1'b1;
            end else if (drain) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            // wr_ready is low here, so only a drain can happen.
            if (drain) begin
               state_nxt      = ONE;
               load_head_tail = 1'b1;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // Buffer storage; contents are don't-care once the occupancy says the slot is empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_addr <= '0;
         head_data <= '0;
         tail_addr <= '0;
         tail_data <= '0;
      end else begin
         if (load_head_wr) begin
            head_addr <= wr_addr;
            head_data <= wr_data;
         end else if (load_head_tail) begin
            head_addr <= tail_addr;
            head_data <= tail_data;
         end
         if (load_tail_wr) begin
            tail_addr <= wr_addr;
            tail_data <= wr_data;
         end
      end
   end

   // Memory port mux: display read wins, otherwise drain the head, otherwise park at zero.
   always_comb begin
      mem_addr = '0;
      mem_we   = 1'b0;
      mem_din  = '0;
      if (disp_valid) begin
         mem_addr = disp_addr;
      end else if (drain) begin
         mem_addr = head_addr;
         mem_din  = head_data;
         mem_we   = head_in_range;
      end
   end

   // Track which cycles carry read data back from memory, and flag committed writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_issued <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         rd_issued <= disp_valid;
         wr_done   <= mem_we;
      end
   end

   // Sticky out-of-range flag; a new violation beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (drain && !head_in_range) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

   assign disp_data = rd_issued ? mem_dout : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a long random run.
// A queue-level model predicts every output each cycle; a commit scoreboard checks write order.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_vram_arbiter;
   localparam int AW    = 17;
   localparam int DW    = 12;
   localparam int DEPTH = 76800;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          disp_valid = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic [DW-1:0] disp_data;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_done;
   logic          err_clr = 1'b0;
   logic          err;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;

   int errors = 0;
   int checks = 0;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_data(disp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .err_clr(err_clr), .err(err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial forever #20 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t q[$];     // model: pending writes in acceptance order
   wr_t acc[$];   // scoreboard: in-range writes still owed to memory
   bit  rd_prev = 1'b0;
   bit  we_prev = 1'b0;
   bit  err_m   = 1'b0;

   // Model: predicts every output from the pending-write list, then advances one clock.
   always @(negedge clk) begin : compare
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      bit            dr;
      bit            acpt;
      wr_t           w;
      if (!rst) begin
         q.delete();
         acc.delete();
         rd_prev = 1'b0;
         we_prev = 1'b0;
         err_m   = 1'b0;
      end
      e_we = 1'b0; e_addr = '0; e_din = '0; dr = 1'b0;
      if (disp_valid) begin
         e_addr = disp_addr;
      end else if (q.size() > 0) begin
         dr     = 1'b1;
         e_addr = q[0].a;
         e_din  = q[0].d;
         e_we   = (int'(q[0].a) < DEPTH);
      end
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_din", mem_din, e_din);
      chk("wr_ready", wr_ready, (q.size() < 2));
      chk("disp_data", disp_data, rd_prev ? mem_dout : 12'h000);
      chk("wr_done", wr_done, we_prev);
      chk("err", err, err_m);
      if (mem_we === 1'b1) begin
         chk("we_during_read", disp_valid, 1'b0);
         chk("commit_pending", (acc.size() > 0), 1'b1);
         if (acc.size() > 0) begin
            chk("commit_addr", mem_addr, acc[0].a);
            chk("commit_data", mem_din, acc[0].d);
            acc.pop_front();
         end
      end
      if (rst) begin
         acpt = wr_valid && (q.size() < 2);
         if (dr && !e_we) err_m = 1'b1;
         else if (err_clr) err_m = 1'b0;
         we_prev = e_we;
         rd_prev = disp_valid;
         if (dr) q.pop_front();
         if (acpt) begin
            w.a = wr_addr;
            w.d = wr_data;
            q.push_back(w);
            if (int'(wr_addr) < DEPTH) acc.push_back(w);
         end
      end
   end

   logic [AW-1:0] sa [3];
   logic [DW-1:0] sd [3];
   int  idx;
   int  run;
   bit  took;

   initial begin
      // Reset state
      tick();
      @(negedge clk);
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_wr_done", wr_done, 1'b0);
      chk("rst_disp_data", disp_data, 12'h000);
      tick();
      rst = 1'b1;

      // Display read: address same cycle, data next cycle
      disp_valid = 1'b1; disp_addr = 17'h00140;
      @(negedge clk);
      chk("rd_addr", mem_addr, 17'h00140);
      chk("rd_we", mem_we, 1'b0);
      tick();
      disp_valid = 1'b0; mem_dout = 12'hABC;
      @(negedge clk);
      chk("rd_data", disp_data, 12'hABC);
      chk("rd_we2", mem_we, 1'b0);
      tick();
      mem_dout = 12'h000;

      // Single write while idle
      wr_valid = 1'b1; wr_addr = 17'h00010; wr_data = 12'hF00;
      @(negedge clk);
      chk("w1_ready", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("w1_we", mem_we, 1'b1);
      chk("w1_addr", mem_addr, 17'h00010);
      chk("w1_din", mem_din, 12'hF00);
      chk("w1_done_early", wr_done, 1'b0);
      tick();
      @(negedge clk);
      chk("w1_done", wr_done, 1'b1);
      chk("w1_we_off", mem_we, 1'b0);
      tick();
      @(negedge clk);
      chk("w1_done_off", wr_done, 1'b0);
      tick();

      // Writes held off by a 10-cycle display run
      sa[0] = 17'h00100; sd[0] = 12'h111;
      sa[1] = 17'h00200; sd[1] = 12'h222;
      sa[2] = 17'h00300; sd[2] = 12'h333;
      idx = 0;
      for (int c = 0; c < 13; c++) begin
         disp_valid = (c < 10);
         disp_addr  = 17'(c);
         if (idx < 3) begin
            wr_valid = 1'b1; wr_addr = sa[idx]; wr_data = sd[idx];
         end else begin
            wr_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 2) chk("run_ready_hi", wr_ready, 1'b1);
         if (c == 2) chk("run_ready_lo", wr_ready, 1'b0);
         if (c < 10) chk("run_no_we", mem_we, 1'b0);
         if (c == 10) begin
            chk("run_c1_we", mem_we, 1'b1);
            chk("run_c1_addr", mem_addr, 17'h00100);
         end
         if (c == 11) begin
            chk("run_c2_we", mem_we, 1'b1);
            chk("run_c2_addr", mem_addr, 17'h00200);
            chk("run_ready_back", wr_ready, 1'b1);
         end
         if (c == 12) begin
            chk("run_c3_we", mem_we, 1'b1);
            chk("run_c3_addr", mem_addr, 17'h00300);
         end
         if (wr_valid && wr_ready) idx++;
         tick();
      end
      disp_valid = 1'b0; wr_valid = 1'b0;
      repeat (3) tick();

      // Out-of-range write at exactly DEPTH
      wr_valid = 1'b1; wr_addr = 17'h12C00; wr_data = 12'h555;
      @(negedge clk);
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("oor_we", mem_we, 1'b0);
      chk("oor_err_pre", err, 1'b0);
      tick();
      err_clr = 1'b1;
      @(negedge clk);
      chk("oor_err", err, 1'b1);
      chk("oor_no_done", wr_done, 1'b0);
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      chk("oor_err_clr", err, 1'b0);
      tick();

      // Reset with a full buffer discards it
      disp_valid = 1'b1;
      wr_valid = 1'b1; wr_addr = 17'h00400; wr_data = 12'h444;
      tick();
      wr_addr = 17'h00401; wr_data = 12'h445;
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("full_ready", wr_ready, 1'b0);
      tick();
      rst = 1'b0; disp_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_ready", wr_ready, 1'b1);
      chk("rstmid_we", mem_we, 1'b0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_no_we", mem_we, 1'b0);
         tick();
      end
      wr_valid = 1'b1; wr_addr = 17'h00402; wr_data = 12'h446;
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_we", mem_we, 1'b1);
      chk("post_rst_addr", mem_addr, 17'h00402);
      tick();

      // Random traffic
      took = 1'b0;
      run  = 0;
      for (int i = 0; i < 10000; i++) begin
         if (run == 0) begin
            disp_valid = ~disp_valid;
            run = $urandom_range(1, 12);
         end
         run--;
         disp_addr = 17'($urandom_range(0, DEPTH - 1));
         mem_dout  = 12'($urandom);
         err_clr   = ($urandom_range(0, 31) == 0);
         if (!wr_valid || took) begin
            wr_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0)
               wr_addr = 17'(DEPTH + $urandom_range(0, 131071 - DEPTH));
            else
               wr_addr = 17'($urandom_range(0, DEPTH - 1));
            wr_data = 12'($urandom);
         end
         @(negedge clk);
         took = wr_valid && wr_ready;
         tick();
      end
      disp_valid = 1'b0; wr_valid = 1'b0; err_clr = 1'b0;
      repeat (4) tick();
      chk("sb_drained", acc.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
